// File: rtl/alu_md_pkg.sv
// Shared definitions for alu_md: ctl encodings, engine states, op-kind decode.
package alu_md_pkg;

    localparam logic [3:0] CTL_AND   = 4'b0000;
    localparam logic [3:0] CTL_OR    = 4'b0001;
    localparam logic [3:0] CTL_ADD   = 4'b0010;
    localparam logic [3:0] CTL_XOR   = 4'b0011;
    localparam logic [3:0] CTL_NOR   = 4'b0100;
    localparam logic [3:0] CTL_SLTU  = 4'b0101;
    localparam logic [3:0] CTL_SUB   = 4'b0110;
    localparam logic [3:0] CTL_SLT   = 4'b0111;
    localparam logic [3:0] CTL_MULT  = 4'b1000;
    localparam logic [3:0] CTL_MULTU = 4'b1001;
    localparam logic [3:0] CTL_DIV   = 4'b1010;
    localparam logic [3:0] CTL_DIVU  = 4'b1011;
    localparam logic [3:0] CTL_MFHI  = 4'b1100;
    localparam logic [3:0] CTL_MFLO  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ITER,
        ST_FIX
    } md_state_t;

    typedef struct packed {
        logic is_launch;
        logic is_hilo_read;
    } op_kind_t;

    function automatic op_kind_t decode_op(input logic [3:0] ctl);
        op_kind_t k;
        k.is_launch    = (ctl[3:2] == 2'b10);
        k.is_hilo_read = (ctl[3:1] == 3'b110);
        return k;
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide engine with HI/LO: one shift-add or restoring-subtract
// step per cycle on operand magnitudes, sign fix-up in a final cycle.
module muldiv_seq
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_t          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div_q, div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               bzero_q, bzero_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     shifted, diff, sum;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        mag_a   = (signed_op && a[WIDTH-1]) ? -a : a;
        mag_b   = (signed_op && b[WIDTH-1]) ? -b : b;
        // acc_hi holds the partial product / remainder, acc_lo the multiplier / quotient
        shifted = {acc_hi_q, acc_lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, opb_q};
        sum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        prod    = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        div_d    = div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        bzero_d  = bzero_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_ITER;
                    cnt_d    = '0;
                    acc_hi_d = '0;
                    acc_lo_d = mag_a;
                    opb_d    = mag_b;
                    div_d    = is_div;
                    neg_d    = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                    rneg_d   = signed_op & a[WIDTH-1];
                    bzero_d  = (b == '0);
                end
            end
            ST_ITER: begin
                if (div_q) begin
                    if (diff[WIDTH]) begin
                        acc_hi_d = shifted[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end else begin
                        acc_hi_d = diff[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end
                end else begin
                    acc_hi_d = sum[WIDTH:1];
                    acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (div_q) begin
                    // Divide-by-zero forces an all-ones quotient regardless of signs
                    lo_d = bzero_q ? '1 : (neg_q ? -acc_lo_q : acc_lo_q);
                    hi_d = rneg_q ? -acc_hi_q : acc_hi_q;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            bzero_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            div_q    <= div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            bzero_q  <= bzero_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/alu_md.sv
// EX-stage ALU: combinational logic/arith/compare ops plus HI/LO access and
// multiply/divide launch, with a stall request while a HI/LO dependency is pending.
module alu_md
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [3:0]       ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    op_kind_t         kind;
    logic             md_busy, md_done, start;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic [WIDTH-1:0] res;
    logic             slt_res, sltu_res;

    assign kind  = decode_op(ctl);
    assign start = valid_in & kind.is_launch & ~md_busy;
    assign stall = md_busy & (kind.is_hilo_read | (kind.is_launch & valid_in));

    assign slt_res  = ($signed(a) < $signed(b));
    assign sltu_res = (a < b);

    always_comb begin
        res = '0;
        case (ctl)
            CTL_AND:  res = a & b;
            CTL_OR:   res = a | b;
            CTL_ADD:  res = a + b;
            CTL_SUB:  res = a - b;
            CTL_XOR:  res = a ^ b;
            CTL_NOR:  res = ~(a | b);
            CTL_SLT:  res = {{(WIDTH-1){1'b0}}, slt_res};
            CTL_SLTU: res = {{(WIDTH-1){1'b0}}, sltu_res};
            // HI/LO reads return 0 while the engine is still producing them
            CTL_MFHI: res = md_busy ? '0 : md_hi;
            CTL_MFLO: res = md_busy ? '0 : md_lo;
            default:  res = '0;
        endcase
    end

    assign out  = res;
    assign zero = (res == '0);
    assign busy = md_busy;
    assign done = md_done;

    muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (~ctl[0]),
        .is_div    (ctl[1]),
        .a         (a),
        .b         (b),
        .busy      (md_busy),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo)
    );

endmodule

// File: doc/alu_md.md
# alu_md

Parametrised successor to the datapath ALU for the MIPS core. Single-cycle logical/arithmetic/compare operations stay combinational. Adds an iterative multiply/divide engine with architectural HI/LO registers, serving MULT/MULTU/DIV/DIVU/MFHI/MFLO. It sits in EX and returns a stall request to the pipeline controller while a HI/LO dependency is outstanding.

## Interface
- `WIDTH`, default 32: datapath width; must be ≥ 4 and even.
- `clk` input, 1 bit: clock; all state updates on its rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `valid_in` input, 1 bit: qualifies `ctl`/`a`/`b` for multiply/divide launch; combinational ops ignore it.
- `ctl` input, 4 bits: operation select.
- `a`, `b` input, `WIDTH` bits: operands (rs, rt).
- `out` output, `WIDTH` bits: combinational result.
- `zero` output, 1 bit: 1 iff `out` == 0.
- `busy` output, 1 bit: engine not idle.
- `done` output, 1 bit: one-cycle pulse when HI/LO are written.
- `stall` output, 1 bit: pipeline must hold EX this cycle.

## Operation
- Combinational ctl codes:
  - 0000 and; 0001 or; 0010 add; 0110 sub; 0011 xor; 0100 nor.
  - 0111 slt (signed): out = 1/0.
  - 0101 sltu (unsigned): out = 1/0.
  - Add and sub wrap modulo 2^WIDTH; no overflow flag.
- HI/LO read codes:
  - 1100 mfhi: out = HI.
  - 1101 mflo: out = LO.
- Launch codes (out = 0 for these): 1000 mult; 1001 multu; 1010 div; 1011 divu.
- Undefined codes: out = 0, zero = 1.
- Launch conditions:
  - A launch op with `valid_in` = 1 while IDLE is accepted.
  - Accepting a launch latches the operand magnitudes and the sign information.
- Engine states:
  - IDLE: on accept, go to ITER with count = 0.
  - ITER: one shift-add (multiply) or restoring-subtract (divide) step per cycle. At count = WIDTH-1, go to FIX.
  - FIX: apply sign correction, write HI/LO, pulse `done`, return to IDLE.
- Multiply results: HI:LO = full 2·WIDTH product. Signed for mult, unsigned for multu.
- Divide results: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Divide by zero: LO = all ones, HI = a. No exception is raised.
- Signed overflow case (most-negative / -1): LO = most-negative, HI = 0.
- `stall` = 1 in either case:
  - `busy` is high and ctl is mfhi, mflo, or any launch op with `valid_in`.
  - While stalled, out = 0 for those ops.
  - A launch while busy is not accepted; it is retried by the held pipeline.
- Combinational ops never stall, even while busy.

## Timing
- Reset values: HI = 0, LO = 0, state IDLE, `busy` = 0, `done` = 0, `stall` = 0.
- With `ctl` = 0000 and a = b = 0 during reset: `out` = 0, `zero` = 1.
- Reset mid-operation aborts immediately; HI/LO are cleared and no `done` pulse is produced.
- Cycle-level sequence (accept edge = E0):
  - Accept edge E0: `busy` rises after E0.
  - Edges E1..E_WIDTH: iteration steps.
  - Edge E_WIDTH+1: HI/LO written, `done` = 1 for exactly one cycle, `busy` falls.
- Latency: WIDTH+1 cycles (33 for WIDTH = 32), independent of operand values.
- Back-to-back operation: a launch presented in the cycle `done` is high is accepted at the next edge.
- mfhi/mflo in the `done` cycle returns the new HI/LO.
- `out`, `zero` and `stall` are combinational from the inputs and the current state.

## Structure
- Package `alu_md_pkg`:
  - ctl code localparams.
  - engine state enum (IDLE/ITER/FIX).
  - op-kind decode function (is_launch, is_hilo_read).
- Sub-module `muldiv_seq` holds everything sequential:
  - iterative engine, counter, sign fix-up, HI/LO.
  - ports: start, signed, is_div, a, b, busy, done, hi, lo.
- The top level holds the combinational ALU mux, zero flag and stall logic.

## Test plan
- Reset, then add 7+5 -> out = 12, zero = 0. Sub 5-5 -> out = 0, zero = 1.
- Compares: slt 0xFFFFFFFF vs 1 -> out = 1. Same operands with sltu -> out = 0.
- mult with a = -3, b = 7:
  - `done` at cycle 33.
  - mfhi -> 0xFFFFFFFF; mflo -> 0xFFFFFFEB.
- Divides:
  - divu 100/7 -> LO = 14, HI = 2.
  - div -7/2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - div 5/0 -> LO = 0xFFFFFFFF, HI = 5.
- Hazards during a launched mult:
  - mflo issued while busy -> `stall` = 1 through cycle 32. The op is held and returns the result in the `done` cycle.
  - `and` issued while busy -> no stall.
- Reset and restart:
  - assert `rst` at cycle 10 of a div -> `busy` = 0 immediately, HI = LO = 0, no `done` pulse.
  - A new multu 0xFFFFFFFF·2 then completes -> HI = 1, LO = 0xFFFFFFFE.
